// File: rtl/prime_pkg.sv
// prime_pkg: shared types and constants for the prime_checker block.
//   prime_state_t  : controller states (IDLE, CHECK, DONE)
//   FIRST_ODD_DIV  : first trial divisor used for odd values >= 5
//   DIV_STEP       : increment between successive odd trial divisors
package prime_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } prime_state_t;

  localparam int unsigned FIRST_ODD_DIV = 3;
  localparam int unsigned DIV_STEP      = 2;

endpackage

// File: rtl/prime_sat_counter.sv
// prime_sat_counter: saturating up-counter with synchronous clear.
// Ports:
//   clk     : rising-edge clock
//   clr_i   : synchronous clear (active high), dominates increment
//   inc_i   : increment enable; ignored once the count is all-ones
//   count_o : current count
module prime_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/prime_checker.sv
// prime_checker: sequential primality tester using odd trial division,
// one candidate divisor per cycle, with valid/ready on both sides.
// Optional feature macro: PRIME_STATS_EN adds saturating result counters.
// Ports:
//   clk          : rising-edge clock
//   rst          : synchronous active-high reset
//   in_valid     : in_value is valid
//   in_ready     : block can accept a value (IDLE and not in reset)
//   in_value     : unsigned WIDTH-bit value to test
//   out_valid    : result valid, held until out_ready
//   out_ready    : consumer accepts the result
//   out_prime    : 1 when the tested value is prime
//   out_value    : echo of the tested value
//   out_divisor  : smallest factor found, 0 when prime or value < 2
//   stat_queries : (PRIME_STATS_EN) results delivered, saturating
//   stat_primes  : (PRIME_STATS_EN) prime results delivered, saturating
module prime_checker
  import prime_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_prime,
  output logic [WIDTH-1:0]     out_value,
  output logic [WIDTH-1:0]     out_divisor
`ifdef PRIME_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] stat_queries,
  output logic [CNT_WIDTH-1:0] stat_primes
`endif
);

  localparam int PW = 2 * WIDTH + 2;

  // Elaboration-time parameter sanity check.
  if (WIDTH < 2 || WIDTH > 32 || CNT_WIDTH < 1) begin : g_bad_param
    $error("prime_checker: WIDTH must be 2..32 and CNT_WIDTH >= 1");
  end

  prime_state_t     state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH:0]   d_q, d_d;
  logic             prime_q, prime_d;
  logic [WIDTH-1:0] div_q, div_d;

  logic             hs_in;
  logic             hs_out;
  logic [PW-1:0]    d_sq;
  logic [PW-1:0]    n_ext;
  logic [WIDTH:0]   d_safe;
  logic [WIDTH:0]   rem;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign hs_in     = in_valid && in_ready;
  assign hs_out    = out_valid && out_ready;

  // Square at 2*WIDTH+2 bits so d*d never wraps, even for n = 2^WIDTH-1.
  assign d_sq  = {{(WIDTH + 1){1'b0}}, d_q} * {{(WIDTH + 1){1'b0}}, d_q};
  assign n_ext = {{(WIDTH + 2){1'b0}}, n_q};

  // d_q is only meaningful in CHECK; keep the divider away from zero elsewhere.
  assign d_safe = (state_q == CHECK) ? d_q : {{WIDTH{1'b0}}, 1'b1};
  assign rem    = {1'b0, n_q} % d_safe;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    prime_d = prime_q;
    div_d   = div_q;
    unique case (state_q)
      IDLE: begin
        if (hs_in) begin
          n_d = in_value;
          // Trivial cases are classified directly from the incoming value.
          if (in_value < WIDTH'(2)) begin
            state_d = DONE;
            prime_d = 1'b0;
            div_d   = '0;
          end else if (in_value == WIDTH'(2) || in_value == WIDTH'(3)) begin
            state_d = DONE;
            prime_d = 1'b1;
            div_d   = '0;
          end else if (!in_value[0]) begin
            state_d = DONE;
            prime_d = 1'b0;
            div_d   = WIDTH'(2);
          end else begin
            state_d = CHECK;
            d_d     = (WIDTH + 1)'(FIRST_ODD_DIV);
          end
        end
      end
      CHECK: begin
        // Past sqrt(n) with no factor found means n is prime.
        if (d_sq > n_ext) begin
          state_d = DONE;
          prime_d = 1'b1;
          div_d   = '0;
        end else if (rem == '0) begin
          // d <= sqrt(n) < 2^WIDTH here, so the top bit of d is zero.
          state_d = DONE;
          prime_d = 1'b0;
          div_d   = d_q[WIDTH-1:0];
        end else begin
          d_d = d_q + (WIDTH + 1)'(DIV_STEP);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      d_q     <= '0;
      prime_q <= 1'b0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      prime_q <= prime_d;
      div_q   <= div_d;
    end
  end

  assign out_prime   = prime_q;
  assign out_value   = n_q;
  assign out_divisor = div_q;

`ifdef PRIME_STATS_EN
  prime_sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_stat_queries (
    .clk    (clk),
    .clr_i  (rst),
    .inc_i  (hs_out),
    .count_o(stat_queries)
  );

  prime_sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_stat_primes (
    .clk    (clk),
    .clr_i  (rst),
    .inc_i  (hs_out && prime_q),
    .count_o(stat_primes)
  );
`else
  // Output handshake only drives the statistics counters.
  logic unused_hs_out;
  assign unused_hs_out = hs_out;
`endif

endmodule

// File: tb/tb_prime_checker.sv
// tb_prime_checker: scoreboard bench for prime_checker (WIDTH=8).
// Stimulus pushes expected results computed from plain arithmetic; an
// independent monitor pops and compares whenever out_valid appears.
module tb_prime_checker;

  localparam int W = 8;
`ifdef PRIME_STATS_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_value;
  logic         out_valid;
  logic         out_ready;
  logic         out_prime;
  logic [W-1:0] out_value;
  logic [W-1:0] out_divisor;
`ifdef PRIME_STATS_EN
  logic [CW-1:0] stat_queries;
  logic [CW-1:0] stat_primes;
`endif

  prime_checker #(
    .WIDTH    (W),
    .CNT_WIDTH(CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_prime  (out_prime),
    .out_value  (out_value),
    .out_divisor(out_divisor)
`ifdef PRIME_STATS_EN
    ,
    .stat_queries(stat_queries),
    .stat_primes (stat_primes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int n_queries = 0;
  int n_primes = 0;

  typedef struct {
    int value;
    int prime;
    int div;
    int exp_cyc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: direct definitions of primality and smallest factor.
  function automatic int ref_prime(input int n);
    if (n < 2) return 0;
    for (int k = 2; k < n; k++) if (n % k == 0) return 0;
    return 1;
  endfunction

  function automatic int ref_factor(input int n);
    if (n < 2) return 0;
    for (int k = 2; k < n; k++) if (n % k == 0) return k;
    return 0;
  endfunction

  // Cycles from input handshake to first out_valid.
  function automatic int ref_latency(input int n);
    int stop;
    if (n < 4 || (n % 2) == 0) return 1;
    if (ref_prime(n) == 1) begin
      stop = 3;
      while (stop * stop <= n) stop += 2;
    end else begin
      stop = ref_factor(n);
    end
    return 1 + ((stop - 3) / 2 + 1);
  endfunction

  // Monitor: compares each presented result against the scoreboard head
  // and checks that it stays stable while back-pressured.
  initial begin : monitor
    bit   active;
    exp_t e;
    int   f_prime, f_div, f_val;
    active = 0;
    f_prime = 0;
    f_div = 0;
    f_val = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0;
      end else if (out_valid) begin
        if (in_ready) check("in_ready_with_out_valid", int'(in_ready), 0);
        if (!active) begin
          active  = 1;
          f_prime = int'(out_prime);
          f_div   = int'(out_divisor);
          f_val   = int'(out_value);
          if (sb.size() == 0) begin
            check("unexpected_out_valid", int'(out_valid), 0);
          end else begin
            e = sb.pop_front();
            $display("txn value=%0d prime=%0d divisor=%0d cycle=%0d", out_value, out_prime, out_divisor, cyc);
            check("out_value", int'(out_value), e.value);
            check("out_prime", int'(out_prime), e.prime);
            check("out_divisor", int'(out_divisor), e.div);
            check("latency_cycle", cyc, e.exp_cyc);
          end
        end else begin
          check("stable_prime", int'(out_prime), f_prime);
          check("stable_divisor", int'(out_divisor), f_div);
          check("stable_value", int'(out_value), f_val);
        end
        if (out_ready) active = 0;
      end else begin
        active = 0;
      end
    end
  end

  task automatic run_txn(input int v, input int hold);
    exp_t e;
    bit   ok;
    @(posedge clk);
    #1;
    in_value  = W'(v);
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("in_ready_timeout", int'(in_ready), 1);
      in_valid = 1'b0;
      return;
    end
    e.value   = v;
    e.prime   = ref_prime(v);
    e.div     = (e.prime == 1) ? 0 : ref_factor(v);
    e.exp_cyc = cyc + ref_latency(v);
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_value = W'($urandom);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("out_valid_timeout", int'(out_valid), 1);
      if (sb.size() > 0) void'(sb.pop_back());
      out_ready = 1'b1;
      return;
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    @(posedge clk);
    n_queries++;
    n_primes += e.prime;
    @(negedge clk);
    check("in_ready_after_accept", int'(in_ready), 1);
  endtask

  task automatic abort_251();
    int seen;
    @(posedge clk);
    #1;
    in_value  = W'(251);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("abort_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("in_ready_during_rst", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_out_valid", seen, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_value  = '0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_prime", int'(out_prime), 0);
      check("rst_out_value", int'(out_value), 0);
      check("rst_out_divisor", int'(out_divisor), 0);
      check("rst_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", int'(in_ready), 1);
`ifdef PRIME_STATS_EN
    check("rst_stat_queries", int'(stat_queries), 0);
    check("rst_stat_primes", int'(stat_primes), 0);
`endif

    for (int v = 0; v < 16; v++) run_txn(v, 0);
    run_txn(251, 0);
    run_txn(255, 0);
    run_txn(221, 0);
    run_txn(25, 5);
    abort_251();
    run_txn(7, 0);

    for (int i = 0; i < 60; i++) begin
      run_txn(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    end

`ifdef PRIME_STATS_EN
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_queries = 0;
    n_primes  = 0;
    run_txn(2, 0);
    run_txn(3, 0);
    run_txn(5, 0);
    run_txn(7, 0);
    run_txn(11, 0);
    run_txn(9, 0);
    check("stat_primes", int'(stat_primes), (n_primes > 3) ? 3 : n_primes);
    check("stat_queries", int'(stat_queries), (n_queries > 3) ? 3 : n_queries);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
